// File: rtl/ym_slot_pkg.sv
// Shared definitions for the time-multiplexed slot counter bank and the
// per-channel logic around it.
//   YM_SLOT_DEF_WIDTH / YM_SLOT_DEF_DEPTH : default counter width / slot count
//   slot_w()                              : slot index width for a given depth
//   slot_t                                : slot index type at default depth
//   cnt_mode_e                            : adder mode decoded from {dec, c_in}
package ym_slot_pkg;

  localparam int unsigned YM_SLOT_DEF_WIDTH = 4;
  localparam int unsigned YM_SLOT_DEF_DEPTH = 6;

  // Index width for a ring of 'depth' slots; never narrower than one bit.
  function automatic int unsigned slot_w(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  localparam int unsigned YM_SLOT_DEF_SW = slot_w(YM_SLOT_DEF_DEPTH);

  typedef logic [YM_SLOT_DEF_SW-1:0] slot_t;

  typedef enum logic [1:0] {
    MODE_HOLD0 = 2'b00,  // dec=0, c_in=0: hold, carry 0
    MODE_INC   = 2'b01,  // dec=0, c_in=1: increment
    MODE_DEC   = 2'b10,  // dec=1, c_in=0: decrement, carry 0 means borrow
    MODE_HOLD1 = 2'b11   // dec=1, c_in=1: hold, carry 1
  } cnt_mode_e;

endpackage

// File: rtl/ym_slot_cnt_next.sv
// Shared adder of the slot counter bank: purely combinational.
// Computes the next value of the slot currently at the ring tail.
//   val      : current tail value
//   c_in     : carry / increment input
//   dec      : add all-ones (decrement mode)
//   load     : use load_val instead of val as the adder base
//   load_val : parallel load value
//   clr      : force next value to zero (dominates load and saturation)
//   next_val : value to be staged for this slot
//   c_out    : raw adder carry
// Option: define YM_SLOT_CNT_SAT_EN for saturating instead of wrapping
// arithmetic; c_out stays the raw carry either way.
module ym_slot_cnt_next
  import ym_slot_pkg::*;
#(
  parameter int unsigned WIDTH = YM_SLOT_DEF_WIDTH
) (
  input  logic [WIDTH-1:0] val,
  input  logic             c_in,
  input  logic             dec,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr,
  output logic [WIDTH-1:0] next_val,
  output logic             c_out
);

  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;
`ifdef YM_SLOT_CNT_SAT_EN
  cnt_mode_e        mode;
`endif

  always_comb begin
    base     = load ? load_val : val;
    addend   = dec ? '1 : '0;
    sum      = {1'b0, base} + {1'b0, addend} + {{WIDTH{1'b0}}, c_in};
    c_out    = sum[WIDTH];
    next_val = sum[WIDTH-1:0];
`ifdef YM_SLOT_CNT_SAT_EN
    mode = cnt_mode_e'({dec, c_in});
    case (mode)
      MODE_INC: if (c_out)  next_val = '1;  // overflow pins at max
      MODE_DEC: if (!c_out) next_val = '0;  // borrow pins at zero
      default:  ;
    endcase
`endif
    if (clr) next_val = '0;
  end

endmodule

// File: rtl/ym_slot_cnt_ring.sv
// Time-multiplexed counter bank: DEPTH independent WIDTH-bit counters
// circulate through a ring shift register and share one adder.
//   MCLK     : master clock, rising edge
//   rst      : synchronous active-high reset (overrides c1/c2)
//   c1       : phase-1 enable, stage <= next value of the tail slot
//   c2       : phase-2 enable, shift ring, stage -> head, advance slot index
//   c_in     : carry / increment for the current slot
//   dec      : decrement mode (add all-ones)
//   load     : replace tail value with load_val before the add
//   load_val : parallel load value
//   clr      : force next value to zero, dominates load
//   sync     : on a c2 cycle, relabel the slot index to 0
//   val      : current slot value (ring tail)
//   c_out    : adder carry for the current slot
//   slot     : index of the slot at the tail
//   wrap     : slot == DEPTH-1
// Option: YM_SLOT_CNT_SAT_EN selects saturating arithmetic in the adder.
module ym_slot_cnt_ring
  import ym_slot_pkg::*;
#(
  parameter int unsigned WIDTH = YM_SLOT_DEF_WIDTH,
  parameter int unsigned DEPTH = YM_SLOT_DEF_DEPTH,
  parameter int unsigned SW    = slot_w(DEPTH)
) (
  input  logic             MCLK,
  input  logic             rst,
  input  logic             c1,
  input  logic             c2,
  input  logic             c_in,
  input  logic             dec,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr,
  input  logic             sync,
  output logic [WIDTH-1:0] val,
  output logic             c_out,
  output logic [SW-1:0]    slot,
  output logic             wrap
);

  logic [WIDTH-1:0] ring_q [DEPTH];
  logic [WIDTH-1:0] ring_d [DEPTH];
  logic [WIDTH-1:0] stage_q, stage_d;
  logic [SW-1:0]    slot_q, slot_d;
  logic [WIDTH-1:0] next_val;

  ym_slot_cnt_next #(
    .WIDTH(WIDTH)
  ) u_next (
    .val      (ring_q[DEPTH-1]),
    .c_in     (c_in),
    .dec      (dec),
    .load     (load),
    .load_val (load_val),
    .clr      (clr),
    .next_val (next_val),
    .c_out    (c_out)
  );

  assign val  = ring_q[DEPTH-1];
  assign slot = slot_q;
  assign wrap = (slot_q == SW'(DEPTH-1));

  // c1 and c2 together are legal: the shift uses the pre-edge stage while
  // stage simultaneously captures the adder result of the pre-edge tail.
  always_comb begin
    ring_d  = ring_q;
    stage_d = stage_q;
    slot_d  = slot_q;
    if (c1) stage_d = next_val;
    if (c2) begin
      ring_d[0] = stage_q;
      for (int unsigned i = 1; i < DEPTH; i++) ring_d[i] = ring_q[i-1];
      if (sync || (slot_q == SW'(DEPTH-1))) slot_d = '0;
      else                                  slot_d = slot_q + SW'(1);
    end
  end

  always_ff @(posedge MCLK) begin
    if (rst) begin
      ring_q  <= '{default: '0};
      stage_q <= '0;
      slot_q  <= '0;
    end else begin
      ring_q  <= ring_d;
      stage_q <= stage_d;
      slot_q  <= slot_d;
    end
  end

endmodule

// File: doc/ym_slot_cnt_ring.md
# ym_slot_cnt_ring

Time-multiplexed counter bank: `DEPTH` independent `WIDTH`-bit counters share one adder. Their values circulate through a ring shift register clocked by the two-phase `c1`/`c2` enables. This generalises the single-bit two-phase counter cells to many slots, with the following additions:
- up/down counting
- parallel load
- per-slot clear
- slot index tracking with a resync input

It sits between the chip-level phase generator and per-channel logic: timers, envelope counters and channel sequencers.

## Interface
Parameters:
- `WIDTH`, 4: bits per slot counter, ≥1.
- `DEPTH`, 6: number of slots in the ring, ≥2.
- `SW`, `$clog2(DEPTH)`: slot index width, derived.

Ports (clock and reset first):
- `MCLK`  in  1  master clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `c1`  in  1  phase-1 enable: compute the next value of the tail slot into the staging register.
- `c2`  in  1  phase-2 enable: shift the ring and push the staging register into the head.
- `c_in`  in  1  carry/increment input for the current slot.
- `dec`  in  1  1 = add all-ones (decrement mode).
- `load`  in  1  replace the tail value with `load_val` before the add.
- `load_val`  in  `WIDTH`  parallel load value.
- `clr`  in  1  force the next value to 0; dominates `load`.
- `sync`  in  1  resync the slot index to 0 on the next `c2` cycle.
- `val`  out  `WIDTH`  value of the current slot (ring tail).
- `c_out`  out  1  adder carry for the current slot.
- `slot`  out  `SW`  index of the slot currently at the tail.
- `wrap`  out  1  `slot == DEPTH-1`.

## Operation
- State:
  - `ring[0..DEPTH-1]`, each `WIDTH` bits.
  - `stage`, `WIDTH` bits.
  - `slot_q`, `SW` bits.
  - `val = ring[DEPTH-1]`.
- Adder, combinational:
  - `base = load ? load_val : val`.
  - `sum[WIDTH:0] = {0,base} + (dec ? {WIDTH{1}} : 0) + c_in`.
  - `c_out = sum[WIDTH]`.
  - `next = clr ? 0 : sum[WIDTH-1:0]`.
- Mode table:
  - `dec=0,c_in=1`: increment.
  - `dec=1,c_in=0`: decrement; `c_out=0` signals borrow, i.e. `base` was 0.
  - `dec=1,c_in=1`: hold, `c_out=1`.
  - `dec=0,c_in=0`: hold, `c_out=0`.
- `c1` cycle: `stage <= next`.
- `c2` cycle:
  - `ring[0] <= stage`; `ring[i] <= ring[i-1]`.
  - `slot_q <= sync ? 0 : (slot_q == DEPTH-1 ? 0 : slot_q+1)`.
- `c1` and `c2` in the same cycle: both updates happen, using pre-edge values (`ring[0]` gets the old `stage`). This is legal, not an error.
- Neither enable high: all state holds.
- `sync` only relabels the index. Ring contents are untouched.
- `sync` is ignored when `c2=0`.

## Timing
- Reset: `ring`, `stage` and `slot_q` all become 0. `val=0`, `slot=0`, `wrap=0`. `c_out` follows the inputs, with `val=0`.
- `rst` asserted mid-operation: the reset takes effect at that edge and overrides `c1`/`c2`.
- Outputs `val`, `slot` and `wrap` change only on `c2` edges. `c_out` is combinational from the inputs and `val`.
- Round trip for one slot: the value computed on a `c1` for slot k appears on `val` again after exactly `DEPTH` further `c2` cycles. `slot` equals k at that point.
- Index wrap: `DEPTH-1 → 0` on `c2`. `wrap` is high for exactly one shift period per revolution when there is no `sync`.
- Required ordering: a `c1` cycle must come before each `c2` cycle. Two `c2` cycles with no `c1` between them re-push the stale `stage` value. This is defined behaviour, not guarded.

## Configuration
- `YM_SLOT_CNT_SAT_EN` defined: saturating arithmetic.
  - If `dec=0` and `c_out=1`, `next = {WIDTH{1}}`.
  - If `dec=1`, `c_in=0` and `c_out=0`, `next = 0`.
  - `clr` still dominates.
  - `c_out` remains the raw adder carry.
- `YM_SLOT_CNT_SAT_EN` undefined: modulo-2^`WIDTH` wrap-around, `next = sum[WIDTH-1:0]`.

## Structure
- Shared package `ym_slot_pkg`:
  - the `$clog2` slot-width helper;
  - default `WIDTH` and `DEPTH` constants;
  - a shared `slot_t` typedef used by channel logic.
- One sub-module, `ym_slot_cnt_next`: purely combinational. It computes `base`, `sum`, `c_out` and `next`, including the saturation option.
- The top level holds only `ring`, `stage` and `slot_q`.

## Test plan
- Reset, then 6 `c1`/`c2` pairs with `c_in=1`, `dec=0` (`WIDTH=4`, `DEPTH=6`) → every slot reads 1 on its next visit; `slot` runs 0..5,0; `wrap` is high only at `slot=5`.
- Slot 2 only: `c_in=1` for 17 revolutions, other slots `c_in=0` → slot 2 reads 1 (wrapped 15→0→1); `c_out=1` on the 16th increment. With `YM_SLOT_CNT_SAT_EN` defined: slot 2 reads 15.
- Slot 3 holds 0; `dec=1`, `c_in=0` → `c_out=0` and the value becomes 15. With the saturation macro: the value stays 0.
- `load=1`, `load_val=9`, `c_in=1` on slot 1; same cycle `clr=1` on slot 4 with value 7 → next visit: slot 1 = 10, slot 4 = 0.
- `sync=1` on a `c2` cycle while `slot=3` → `slot=0` after that edge; ring data unchanged (previous slot-4 value now reported at `slot=0`).
- `c1` and `c2` high together from a known state → `ring[0]` gets the old `stage`; `stage` gets `next` of the pre-edge tail. Then assert `rst` mid-revolution → all outputs 0 at the next edge.
